// File: rtl/gsm_link_pkg.sv
// Shared types and UART handshake constants for the GSM link transmit path.
package gsm_link_pkg;

  localparam int BYTE_W = 8;

  // Default inter-byte spacing and tx_done watchdog, shared with the GSM sender.
  localparam int GSM_GAP_CYCLES     = 90000;
  localparam int GSM_TIMEOUT_CYCLES = 1000000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    GAP
  } arb_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward from rr_ptr+1 with wrap.
module rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of this always_comb gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    // Walk from the farthest candidate back to the nearest so the nearest match wins.
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ byte-stream requesters: packet-locked round-robin
// grants, programmable inter-byte gap, and timeout recovery from a lost tx_done.
module uart_tx_arbiter
  import gsm_link_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = GSM_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = GSM_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        byte_vld,
  input  logic [N_REQ-1:0]        byte_last,
  input  logic [BYTE_W*N_REQ-1:0] byte_data,
  output logic [N_REQ-1:0]        byte_ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    tx_enable,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
  // GAP_CYCLES=0 shares the terminal count of 1, so GAP still lasts one cycle.
  localparam logic [CNT_W-1:0] GAP_TC = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_TC  = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  own_q, own_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic [N_REQ-1:0]  grant_d, byte_ack_d;
  logic              tx_enable_d, busy_d, timeout_err_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic [BYTE_W-1:0] lanes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lanes[i] = byte_data[i*BYTE_W +: BYTE_W];
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    own_d         = own_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    grant_d       = grant;
    tx_enable_d   = tx_enable;
    tx_data_d     = tx_data;
    byte_ack_d    = '0;
    timeout_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick_gnt;
          own_d   = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!req[own_q]) begin
          grant_d  = '0;
          rr_ptr_d = own_q;
          state_d  = IDLE;
        end else if (byte_vld[own_q]) begin
          tx_data_d   = lanes[own_q];
          tx_enable_d = 1'b1;
          byte_ack_d  = grant;
          last_d      = byte_last[own_q];
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // tx_done is checked first so a completion on the timeout cycle is not an error.
        if (tx_done) begin
          tx_enable_d = 1'b0;
          cnt_d       = '0;
          state_d     = GAP;
        end else if (cnt_q == TO_TC) begin
          tx_enable_d   = 1'b0;
          timeout_err_d = 1'b1;
          grant_d       = '0;
          rr_ptr_d      = own_q;
          cnt_d         = '0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_TC) begin
          cnt_d = '0;
          if (last_q || !req[own_q]) begin
            grant_d  = '0;
            rr_ptr_d = own_q;
            state_d  = IDLE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDX_W'(N_REQ - 1);
      own_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      grant       <= '0;
      byte_ack    <= '0;
      tx_enable   <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant       <= grant_d;
      byte_ack    <= byte_ack_d;
      tx_enable   <= tx_enable_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule
